// File: rtl/branch_target_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_target_buffer: direct-mapped BTB, saturating-counter prediction   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [ADDR_W-1:0] lookup_pc,
    input  logic              lookup_valid,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_next_pc,
    input  logic              update_en,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic [ADDR_W-1:0] update_target,
    input  logic              update_taken,
    input  logic              update_is_jump,
    input  logic              flush_all,
    output logic [15:0]       hit_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_RST = CTR_MAX >> 1;   // weakly not-taken
    localparam logic [CTR_W-1:0] CTR_WT  = ~CTR_RST;       // weakly taken

    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_d    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [ADDR_W-1:0] target_d [ENTRIES];
    logic [CTR_W-1:0]  ctr_q    [ENTRIES];
    logic [CTR_W-1:0]  ctr_d    [ENTRIES];
    logic [15:0]       hit_count_q;
    logic [15:0]       hit_count_d;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             unused_pc_lsbs;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[ADDR_W-1:IDX_W+2];
    assign unused_pc_lsbs = ^update_pc[1:0];

    // Lookup reads the registered table only, so same-cycle updates are not bypassed.
    assign pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken   = pred_hit && ctr_q[lk_idx][CTR_W-1];
    assign pred_next_pc = pred_taken ? target_q[lk_idx] : lookup_pc + ADDR_W'(4);
    assign hit_count    = hit_count_q;

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        valid_d     = valid_q;
        tag_d       = tag_q;
        target_d    = target_q;
        ctr_d       = ctr_q;
        hit_count_d = hit_count_q;

        if (lookup_valid && pred_hit && (hit_count_q != 16'hFFFF)) begin
            hit_count_d = hit_count_q + 16'd1;
        end

        if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (update_en) begin
            if (up_hit) begin
                target_d[up_idx] = update_target;
                if (update_is_jump) begin
                    ctr_d[up_idx] = CTR_MAX;
                end else if (update_taken) begin
                    if (ctr_q[up_idx] != CTR_MAX) ctr_d[up_idx] = ctr_q[up_idx] + 1'b1;
                end else begin
                    if (ctr_q[up_idx] != '0) ctr_d[up_idx] = ctr_q[up_idx] - 1'b1;
                end
            end else if (update_taken || update_is_jump) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = update_target;
                ctr_d[up_idx]    = update_is_jump ? CTR_MAX : CTR_WT;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RST;
            end
            hit_count_q <= '0;
        end else begin
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            target_q    <= target_d;
            ctr_q       <= ctr_d;
            hit_count_q <= hit_count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_branch_target_buffer: randomized bench against an arithmetic BTB model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_branch_target_buffer;

    localparam int ENTRIES = 16;
    localparam int CTR_W   = 2;
    localparam int ADDR_W  = 32;
    localparam int CMAX    = (1 << CTR_W) - 1;
    localparam int CHALF   = (CMAX + 1) / 2;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [ADDR_W-1:0] lookup_pc;
    logic              lookup_valid;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_next_pc;
    logic              update_en;
    logic [ADDR_W-1:0] update_pc;
    logic [ADDR_W-1:0] update_target;
    logic              update_taken;
    logic              update_is_jump;
    logic              flush_all;
    logic [15:0]       hit_count;

    branch_target_buffer #(.ENTRIES(ENTRIES), .CTR_W(CTR_W), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .lookup_pc(lookup_pc), .lookup_valid(lookup_valid),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .update_en(update_en), .update_pc(update_pc), .update_target(update_target),
        .update_taken(update_taken), .update_is_jump(update_is_jump),
        .flush_all(flush_all), .hit_count(hit_count)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: entry fields as plain integers, indexed by arithmetic on the PC.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    int          m_hits;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= CHALF);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        return m_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = '0;
            m_ctr[i]    = CHALF - 1;
        end
        m_hits = 0;
    endtask

    task automatic model_update(input bit ue, input logic [31:0] upc, input logic [31:0] utgt,
                                input bit ut, input bit uj, input bit fl);
        int unsigned ix;
        ix = idx_of(upc);
        if (fl) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        end else if (ue) begin
            if (m_hit(upc)) begin
                m_target[ix] = utgt;
                if (uj)      m_ctr[ix] = CMAX;
                else if (ut) m_ctr[ix] = (m_ctr[ix] + 1 > CMAX) ? CMAX : m_ctr[ix] + 1;
                else         m_ctr[ix] = (m_ctr[ix] - 1 < 0) ? 0 : m_ctr[ix] - 1;
            end else if (ut || uj) begin
                m_valid[ix]  = 1'b1;
                m_tag[ix]    = tag_of(upc);
                m_target[ix] = utgt;
                m_ctr[ix]    = uj ? CMAX : CHALF;
            end
        end
    endtask

    // One clock: drive, compare outputs at the negedge, advance the model at the posedge.
    task automatic cycle(input bit ue, input logic [31:0] upc, input logic [31:0] utgt,
                         input bit ut, input bit uj, input bit fl,
                         input logic [31:0] lpc, input bit lv, input bit chk_en);
        update_en = ue; update_pc = upc; update_target = utgt;
        update_taken = ut; update_is_jump = uj; flush_all = fl;
        lookup_pc = lpc; lookup_valid = lv;
        @(negedge CLK);
        if (chk_en) begin
            check("hit",   {31'b0, pred_hit},   {31'b0, m_hit(lpc)});
            check("taken", {31'b0, pred_taken}, {31'b0, m_taken(lpc)});
            check("next",  pred_next_pc,        m_next(lpc));
            check("hcnt",  {16'b0, hit_count},  m_hits);
        end
        @(posedge CLK);
        if (lv && m_hit(lpc) && m_hits < 65535) m_hits++;
        model_update(ue, upc, utgt, ut, uj, fl);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 9) == 0) return $urandom;
        return ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST = 1'b0;
        update_en = 0; update_pc = '0; update_target = '0; update_taken = 0;
        update_is_jump = 0; flush_all = 0; lookup_pc = 32'h100; lookup_valid = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;

        @(negedge CLK);
        check("rst_hit",   {31'b0, pred_hit},   32'd0);
        check("rst_taken", {31'b0, pred_taken}, 32'd0);
        check("rst_next",  pred_next_pc,        32'h104);
        check("rst_hcnt",  {16'b0, hit_count},  32'd0);
        @(posedge CLK); #1;

        // Allocate; same-cycle lookup still sees the old (empty) entry.
        cycle(1, 32'h100, 32'h80, 1, 0, 0, 32'h100, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 32'h100, 1, 1);
        @(negedge CLK);
        check("alloc_next", pred_next_pc, 32'h80);
        @(posedge CLK); #1;
        if (m_hits < 65535) m_hits++;

        repeat (3) cycle(1, 32'h100, 32'h80, 0, 0, 0, 32'h100, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 32'h100, 0, 1);
        repeat (4) cycle(1, 32'h100, 32'h80, 1, 0, 0, 32'h100, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 32'h100, 0, 1);

        // Aliasing on index 0, then a not-taken miss must not allocate.
        cycle(1, 32'h140, 32'h200, 0, 1, 0, 32'h140, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 32'h140, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 32'h100, 1, 1);
        cycle(1, 32'h180, 32'h400, 0, 0, 0, 32'h140, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 32'h140, 1, 1);

        // Flush beats a concurrent update.
        cycle(1, 32'h104, 32'h300, 1, 0, 1, 32'h140, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 32'h140, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 32'h104, 1, 1);

        cycle(0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 1);
        @(negedge CLK);
        check("wrap_next", pred_next_pc, 32'h0);
        @(posedge CLK); #1;

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 2) != 0, rand_pc(), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 29) == 0, rand_pc(), $urandom_range(0, 1), 1);
        end

        // Asynchronous reset in the middle of an update cycle.
        cycle(1, 32'h100, 32'h80, 1, 0, 0, 32'h100, 1, 1);
        update_en = 1; update_pc = 32'h140; update_target = 32'h200;
        update_taken = 1; update_is_jump = 1; flush_all = 0;
        lookup_pc = 32'h100; lookup_valid = 1;
        #3;
        nRST = 1'b0;
        #1;
        check("arst_hit",   {31'b0, pred_hit},   32'd0);
        check("arst_taken", {31'b0, pred_taken}, 32'd0);
        check("arst_next",  pred_next_pc,        32'h104);
        check("arst_hcnt",  {16'b0, hit_count},  32'd0);
        model_reset();
        update_en = 0;
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
        cycle(0, 0, 0, 0, 0, 0, 32'h100, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 32'h140, 1, 1);

        // Drive the hit counter past its saturation point.
        cycle(1, 32'h100, 32'h80, 1, 0, 0, 32'h100, 1, 1);
        for (int i = 0; i < 70000; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 32'h100, 1, (i % 10000) == 0);
        end
        @(negedge CLK);
        check("hcnt_sat",   {16'b0, hit_count}, 32'h0000_FFFF);
        check("hcnt_model", {16'b0, hit_count}, m_hits);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
